if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. Holds the fetch PC and issues requests to instruction memory over a valid/ack handshake that tolerates variable latency. Buffers returned words in a small prefetch FIFO. Presents the oldest fetched {address, instruction} pair to IF/ID, honouring the hazard unit's stall and the branch unit's flush/redirect.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset.
- DEPTH, 2: prefetch FIFO entries; power of two, at least 2.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- stall_i  input  1  hazard stall from ID; holds the FIFO head.
- flush_i  input  1  branch taken; discards all fetched and in-flight work.
- branch_addr_i  input  32  redirect target, used only when flush_i=1.
- imem_req_o  output  1  memory request valid.
- imem_addr_o  output  32  request address, word aligned.
- imem_ack_i  input  1  memory response strobe; imem_data_i valid in the same cycle.
- imem_data_i  input  32  returned instruction word.
- addr_o  output  32  PC of the FIFO head, to IF/ID addr_i.
- instr_o  output  32  instruction of the FIFO head, to IF/ID instr_i.
- valid_o  output  1  FIFO head is valid.

## Operation
- Reset state: fpc=RESET_PC, FIFO empty, no outstanding request, drop flag=0, imem_req_o=0, valid_o=0, addr_o=0, instr_o=0 (fill value; see Configuration).
- Request issue:
  - imem_req_o is registered.
  - A request is raised when FIFO count + outstanding < DEPTH, flush_i=0, and drop flag=0; at most one request is outstanding.
  - imem_addr_o equals fpc and holds stable while imem_req_o=1.
- Handshake:
  - The request completes at a posedge with imem_req_o=1 and imem_ack_i=1.
  - imem_ack_i while imem_req_o=0 is ignored.
- Push on completion, if not dropped:
  - FIFO receives {fpc, imem_data_i}; fpc <= fpc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - If space remains, imem_req_o stays 1 for the next address in the following cycle.
- Pop: at a posedge with valid_o=1 and stall_i=0. Push and pop in the same cycle are legal; count is unchanged. Overflow is impossible by the issue rule.
- Output: addr_o/instr_o/valid_o are driven combinationally from the FIFO head. When empty: valid_o=0, addr_o=0, instr_o=fill value.
- Flush (priority over stall, pop, and push):
  - FIFO emptied.
  - fpc <= {branch_addr_i[31:2], 2'b00}.
  - If a request is outstanding and not acked that cycle, drop flag=1: imem_req_o and imem_addr_o are held until the ack; the returned word is discarded; drop flag clears. A new request for the target is issued the cycle after.
  - If the ack coincides with flush_i, the word is discarded and fpc takes the target.
  - Repeated flush_i while drop flag=1 only updates fpc.
- Reset mid-handshake: immediate return to the reset state; the memory side must tolerate the abandoned request.

## Timing
- First request: imem_req_o=1 in the first cycle after rst_i deasserts.
- Latency with a zero-wait memory (ack in the request cycle): valid_o=1 the cycle after the request cycle.
- Throughput with a zero-wait memory: one instruction per cycle sustained.
- Stall: the head is held for every stall cycle; prefetch continues until count=DEPTH.
- Flush: valid_o=0 the cycle after flush_i. The target request is raised that same cycle if nothing was outstanding; otherwise the cycle after the dropped ack.

## Configuration
- IF_FETCH_NOP_FILL_EN defined: fill value is 32'h0000_0013 (addi x0,x0,0), so an empty FIFO feeds a NOP bubble.
- IF_FETCH_NOP_FILL_EN undefined: fill value is 32'h0000_0000.
- No other behaviour changes.

## Test plan
- Reset, then a zero-wait memory returning {addr} as data:
  - Requests go to 0, 4, 8, ...
  - valid_o=1 from the second cycle after reset; addr_o advances by 4 each cycle; instr_o equals addr_o.
- 3-wait-state memory:
  - imem_addr_o is held stable for 4 cycles per request.
  - valid_o pulses every 4 cycles; there is no duplicate or skipped address.
- stall_i=1 for 5 cycles with a zero-wait memory:
  - addr_o is frozen; FIFO fills to DEPTH=2; imem_req_o drops.
  - After release, addresses continue in sequence with no gap.
- flush_i with branch_addr_i=32'h0000_0103 while a 2-wait request to 0x10 is outstanding:
  - The 0x10 word is discarded; valid_o=0.
  - The next request goes to 0x100; the next valid addr_o is 0x100.
- FIFO empty:
  - Without the macro: instr_o=0.
  - With IF_FETCH_NOP_FILL_EN: instr_o=32'h13.
- rst_i asserted mid-request: imem_req_o, valid_o, and addr_o go to 0 asynchronously; restart fetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetch PC, valid/ack instruction-memory requests, prefetch FIFO.
// Optional build macro IF_FETCH_NOP_FILL_EN: an empty FIFO presents addi x0,x0,0 instead of zero.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] addr_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

`ifdef IF_FETCH_NOP_FILL_EN
  localparam logic [31:0] FILL = 32'h0000_0013;
`else
  localparam logic [31:0] FILL = 32'h0000_0000;
`endif

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t DEPTH_C = DEPTH[AW:0];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } entry_t;

  entry_t      mem [DEPTH];
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;
  cnt_t        count;
  logic [31:0] fpc;
  logic        drop;

  logic        hold;
  logic        push;
  logic        pop;
  logic [31:0] target;
  cnt_t        count_n;
  logic [31:0] fpc_n;
  logic        drop_n;
  logic        req_n;
  logic [31:0] addr_n;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    hold    = imem_req_o & ~imem_ack_i;
    push    = imem_req_o & imem_ack_i & ~drop & ~flush_i;
    pop     = valid_o & ~stall_i & ~flush_i;
    target  = branch_addr_i & 32'hFFFF_FFFC;
    count_n = count;
    if (flush_i) begin
      count_n = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_n = count + cnt_t'(1);
        2'b01:   count_n = count - cnt_t'(1);
        default: count_n = count;
      endcase
    end
    fpc_n = fpc;
    if (flush_i)   fpc_n = target;
    else if (push) fpc_n = fpc + 32'd4;
    // An unacked request is held until its ack; a flush meanwhile turns that ack into a discard.
    drop_n = hold & (drop | flush_i);
    req_n  = hold | (count_n < DEPTH_C);
    addr_n = hold ? imem_addr_o : fpc_n;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fpc         <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      drop        <= 1'b0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      fpc         <= fpc_n;
      count       <= count_n;
      drop        <= drop_n;
      imem_req_o  <= req_n;
      imem_addr_o <= addr_n;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // NOTE: FIFO storage has no reset; an entry is never read before count says it was written.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{addr: fpc, instr: imem_data_i};
  end

  always_comb begin
    valid_o = (count != '0);
    addr_o  = 32'h0;
    instr_o = FILL;
    if (valid_o) begin
      addr_o  = mem[rd_ptr].addr;
      instr_o = mem[rd_ptr].instr;
    end
  end

endmodule
